// File: rtl/ni_read_rqst_queue_pkg.sv
// Router/PE shared definitions: flit field widths, router info codes, PE address width.
package ni_read_rqst_queue_pkg;

  localparam int ROUTER_INFO_WIDTH = 4;
  localparam int ROUTER_ADDR_WIDTH = 16;
  localparam int ROUTER_DATA_WIDTH = 16;
  localparam int ROUTER_WIDTH      = ROUTER_INFO_WIDTH + ROUTER_ADDR_WIDTH + ROUTER_DATA_WIDTH;

  localparam logic [ROUTER_INFO_WIDTH-1:0] ROUTER_INFO_CONFIG    = 4'h1;
  localparam logic [ROUTER_INFO_WIDTH-1:0] ROUTER_INFO_BROADCAST = 4'h2;
  localparam logic [ROUTER_INFO_WIDTH-1:0] ROUTER_INFO_CALC      = 4'h3;
  localparam logic [ROUTER_INFO_WIDTH-1:0] ROUTER_INFO_WRITE     = 4'h5;
  localparam logic [ROUTER_INFO_WIDTH-1:0] ROUTER_INFO_READ      = 4'h6;

  localparam int PE_ACT_NO_WIDTH = 6;

endpackage

// File: rtl/ni_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO; push while full is accepted only alongside a pop.
module ni_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_eff;
  logic             pop_eff;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);
  assign rdata    = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define validity, so the array maps to plain registers/RAM.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= wdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + AW'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_eff, pop_eff})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ni_read_rqst_queue.sv
// NI read-request queue: captures READ flits' addresses and issues them FIFO to the router.
// Define NI_READ_RQST_ASSERT_EN to compile in simulation-only overflow and issue-trace checks.
module ni_read_rqst_queue
  import ni_read_rqst_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = PE_ACT_NO_WIDTH,
  parameter int IN_W   = ROUTER_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_data_valid,
  input  logic [IN_W-1:0]   in_data,
  input  logic              router_rdy,
  output logic              read_rqst_read_en,
  output logic              ni_read_rqst,
  output logic [ADDR_W-1:0] ni_read_addr
);

  logic                         push;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [ADDR_W-1:0]            head_addr;
  logic [ROUTER_INFO_WIDTH-1:0] info;

  assign info = in_data[IN_W-1 -: ROUTER_INFO_WIDTH];
  assign push = in_data_valid && (info == ROUTER_INFO_READ);

  ni_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (read_rqst_read_en),
    .wdata (in_data[ROUTER_DATA_WIDTH +: ADDR_W]),
    .rdata (head_addr),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ni_read_rqst      = ~fifo_empty;
  assign ni_read_addr      = ni_read_rqst ? head_addr : '0;
  assign read_rqst_read_en = ni_read_rqst & router_rdy;

  // Data field and upper address bits carry nothing for a read request.
  logic unused_in;
  assign unused_in = ^{in_data[ROUTER_DATA_WIDTH-1:0],
                       in_data[IN_W-ROUTER_INFO_WIDTH-1:ROUTER_DATA_WIDTH+ADDR_W], fifo_full};

`ifdef NI_READ_RQST_ASSERT_EN
  always_ff @(posedge clk) begin
    if (!rst && push && fifo_full && !read_rqst_read_en)
      $error("ni_read_rqst_queue: READ flit dropped, queue full");
    if (!rst && read_rqst_read_en)
      $display("@%0t read rqst addr=%0d", $time, ni_read_addr);
  end
`endif

endmodule

// File: tb/tb_ni_read_rqst_queue.sv
// Table-driven bench for ni_read_rqst_queue with an address scoreboard on every issued request.
module tb_ni_read_rqst_queue;
  import ni_read_rqst_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_data_valid;
  logic [35:0] in_data;
  logic        router_rdy;
  logic        read_rqst_read_en;
  logic        ni_read_rqst;
  logic [5:0]  ni_read_addr;

  ni_read_rqst_queue dut (
    .clk               (clk),
    .rst               (rst),
    .in_data_valid     (in_data_valid),
    .in_data           (in_data),
    .router_rdy        (router_rdy),
    .read_rqst_read_en (read_rqst_read_en),
    .ni_read_rqst      (ni_read_rqst),
    .ni_read_addr      (ni_read_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  info;
    logic [15:0] addr;
    logic        rdy;
    logic        exp_rqst;
    logic [5:0]  exp_addr;
    logic        exp_en;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] sb[$];
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic v, input logic [3:0] info, input logic [15:0] addr,
                              input logic rdy, input logic er, input logic [5:0] ea, input logic ee);
    vecs.push_back('{v, info, addr, rdy, er, ea, ee});
  endfunction

  // One cycle: drive at negedge, compare just after, update the scoreboard model.
  task automatic apply(input vec_t t, input int idx);
    logic [5:0] want;
    @(negedge clk);
    in_data_valid = t.v;
    in_data       = {t.info, t.addr, 16'hA5A5};
    router_rdy    = t.rdy;
    #1;
    check($sformatf("row%0d_rqst", idx), 32'(ni_read_rqst), 32'(t.exp_rqst));
    check($sformatf("row%0d_addr", idx), 32'(ni_read_addr), 32'(t.exp_addr));
    check($sformatf("row%0d_en",   idx), 32'(read_rqst_read_en), 32'(t.exp_en));
    if (read_rqst_read_en) begin
      if (sb.size() == 0) check($sformatf("row%0d_sb_empty", idx), 32'd1, 32'd0);
      else begin
        want = sb.pop_front();
        check($sformatf("row%0d_sb_addr", idx), 32'(ni_read_addr), 32'(want));
      end
    end
    if (t.v && t.info == ROUTER_INFO_READ && sb.size() < DEPTH) sb.push_back(t.addr[5:0]);
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
    vecs.delete();
  endtask

  initial begin
    rst           = 1'b1;
    in_data_valid = 1'b1;
    in_data       = {ROUTER_INFO_READ, 16'h0007, 16'h0000};
    router_rdy    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rqst", 32'(ni_read_rqst), 32'd0);
    check("rst_addr", 32'(ni_read_addr), 32'd0);
    check("rst_en",   32'(read_rqst_read_en), 32'd0);
    in_data_valid = 1'b0;
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) add(0, 4'h0, 16'h0, 1'(i % 2), 0, 6'd0, 0);
    // Single READ, no same-cycle bypass
    add(1, ROUTER_INFO_READ, 16'h0015, 1, 0, 6'd0, 0);
    add(0, 4'h0, 16'h0, 1, 1, 6'd21, 1);
    add(0, 4'h0, 16'h0, 1, 0, 6'd0, 0);
    // Non-READ flits ignored
    add(1, ROUTER_INFO_CONFIG,    16'h0015, 1, 0, 6'd0, 0);
    add(1, ROUTER_INFO_BROADCAST, 16'h0015, 1, 0, 6'd0, 0);
    add(1, ROUTER_INFO_CALC,      16'h0015, 1, 0, 6'd0, 0);
    add(1, ROUTER_INFO_WRITE,     16'h0015, 1, 0, 6'd0, 0);
    add(0, 4'h0, 16'h0, 1, 0, 6'd0, 0);
    // Fill with router_rdy low; upper address bits must be discarded
    add(1, ROUTER_INFO_READ, 16'h0041, 0, 0, 6'd0, 0);
    add(1, ROUTER_INFO_READ, 16'h0002, 0, 1, 6'd1, 0);
    add(1, ROUTER_INFO_READ, 16'h0003, 0, 1, 6'd1, 0);
    add(1, ROUTER_INFO_READ, 16'hFFC4, 0, 1, 6'd1, 0);
    add(0, 4'h0, 16'h0, 0, 1, 6'd1, 0);
    add(0, 4'h0, 16'h0, 0, 1, 6'd1, 0);
    // Drain back-to-back
    add(0, 4'h0, 16'h0, 1, 1, 6'd1, 1);
    add(0, 4'h0, 16'h0, 1, 1, 6'd2, 1);
    add(0, 4'h0, 16'h0, 1, 1, 6'd3, 1);
    add(0, 4'h0, 16'h0, 1, 1, 6'd4, 1);
    add(0, 4'h0, 16'h0, 1, 0, 6'd0, 0);
    // Refill, then push+pop while full, then push while full without pop
    add(1, ROUTER_INFO_READ, 16'h0001, 0, 0, 6'd0, 0);
    add(1, ROUTER_INFO_READ, 16'h0002, 0, 1, 6'd1, 0);
    add(1, ROUTER_INFO_READ, 16'h0003, 0, 1, 6'd1, 0);
    add(1, ROUTER_INFO_READ, 16'h0004, 0, 1, 6'd1, 0);
    add(1, ROUTER_INFO_READ, 16'h0009, 1, 1, 6'd1, 1);
    add(0, 4'h0, 16'h0, 0, 1, 6'd2, 0);
    add(1, ROUTER_INFO_READ, 16'h000B, 0, 1, 6'd2, 0);
    add(0, 4'h0, 16'h0, 1, 1, 6'd2, 1);
    add(0, 4'h0, 16'h0, 1, 1, 6'd3, 1);
    add(0, 4'h0, 16'h0, 1, 1, 6'd4, 1);
    add(0, 4'h0, 16'h0, 1, 1, 6'd9, 1);
    add(0, 4'h0, 16'h0, 1, 0, 6'd0, 0);
    // Streaming push and pop every cycle at occupancy one
    add(1, ROUTER_INFO_READ, 16'h0030, 1, 0, 6'd0,  0);
    add(1, ROUTER_INFO_READ, 16'h003F, 1, 1, 6'h30, 1);
    add(1, ROUTER_INFO_READ, 16'h0000, 1, 1, 6'h3F, 1);
    add(0, 4'h0, 16'h0, 1, 1, 6'd0, 1);
    add(0, 4'h0, 16'h0, 1, 0, 6'd0, 0);
    // Two pending entries before a mid-operation reset
    add(1, ROUTER_INFO_READ, 16'h002A, 0, 0, 6'd0,  0);
    add(1, ROUTER_INFO_READ, 16'h0015, 0, 1, 6'd42, 0);
    add(0, 4'h0, 16'h0, 0, 1, 6'd42, 0);
    run_table();

    // Asynchronous reset mid-cycle discards pending entries immediately
    @(negedge clk);
    in_data_valid = 1'b0;
    router_rdy    = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst_rqst", 32'(ni_read_rqst), 32'd0);
    check("midrst_addr", 32'(ni_read_addr), 32'd0);
    check("midrst_en",   32'(read_rqst_read_en), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;

    add(0, 4'h0, 16'h0, 1, 0, 6'd0, 0);
    add(0, 4'h0, 16'h0, 1, 0, 6'd0, 0);
    add(1, ROUTER_INFO_READ, 16'h0005, 1, 0, 6'd0, 0);
    add(0, 4'h0, 16'h0, 1, 1, 6'd5, 1);
    add(0, 4'h0, 16'h0, 1, 0, 6'd0, 0);
    run_table();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ni_read_rqst_queue.md
# ni_read_rqst_queue

Small FIFO in the processing-element network-interface input path. It captures READ-type router packets arriving from the local router port and stores their activation read addresses. It issues the addresses one at a time as read requests toward the router-side output logic. Each issued request pops one entry; the parent returns one upstream credit per pop.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, ≥2; equals the local upstream buffer credit count.
- ADDR_W, 6: read address width (PE activation index width, PeActNoBus).
- IN_W, 36: router flit width (ROUTER_WIDTH).

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_data_valid  in  1  flit on in_data valid this cycle.
- in_data  in  IN_W  flit; [35:32] info, [31:16] addr, [15:0] data.
- router_rdy  in  1  router accepts a read request this cycle.
- read_rqst_read_en  out  1  head entry issued and popped this cycle.
- ni_read_rqst  out  1  read request pending (queue non-empty).
- ni_read_addr  out  ADDR_W  address of head entry.

## Operation
- Push: when in_data_valid and in_data[35:32] == ROUTER_INFO_READ (package constant 4'h6), write in_data[16+ADDR_W-1:16] into the tail entry. All other info codes are ignored; the data field is ignored.
- ni_read_rqst = not empty; ni_read_addr = head entry when non-empty, else 0.
- read_rqst_read_en = ni_read_rqst & router_rdy, combinational; pops the head in the same cycle.
- Storage: entry array of DEPTH×ADDR_W; read/write pointers of log2(DEPTH) bits wrap modulo DEPTH; occupancy count of log2(DEPTH)+1 bits.
- Simultaneous push and pop: both take effect; count unchanged. This is legal even when full.
- Push while full without a pop: dropped; state unchanged. Credit flow makes this unreachable, and the assertion build flags it.
- Pop only occurs when non-empty, by construction.
- Order is strictly FIFO.

## Timing
- Reset: pointers and count cleared to 0. Entries are not cleared.
- Reset outputs: ni_read_rqst=0, ni_read_addr=0, read_rqst_read_en=0.
- Latency: a flit pushed in cycle N appears on ni_read_rqst/ni_read_addr in cycle N+1. There is no same-cycle bypass when empty.
- Back-to-back: with router_rdy held high, one request issues per cycle.
- While router_rdy=0, the head is held stable and ni_read_rqst stays asserted.
- Reset asserted mid-operation discards all pending entries immediately.

## Configuration
- NI_READ_RQST_ASSERT_EN: when defined, simulation-only checks are compiled in:
  - $error on a push while full without a simultaneous pop.
  - $display of "@time read rqst addr=%d" on each read_rqst_read_en.
- When undefined, no checks are present and the synthesized logic is identical.

## Structure
- Shared package (router/pe defs):
  - ROUTER_WIDTH, ROUTER_INFO_WIDTH=4, ROUTER_ADDR_WIDTH=16, ROUTER_DATA_WIDTH=16.
  - ROUTER_INFO_* codes, including ROUTER_INFO_READ=4'h6.
  - PE_ACT_NO_WIDTH=6.
- One sub-module is natural: ni_sync_fifo, a generic DEPTH×WIDTH synchronous FIFO with push/pop/full/empty. This block wraps it with packet decode and the issue handshake.

## Test plan
- Reset, then idle: ni_read_rqst=0, ni_read_addr=0, read_rqst_read_en=0 for 10 cycles.
- Single READ flit (info=6, addr=0x0015), router_rdy=1: in the next cycle ni_read_rqst=1, ni_read_addr=21, read_rqst_read_en=1. The cycle after, all outputs are 0.
- Non-READ flits (info=CONFIG, BROADCAST, CALC) with valid=1: queue stays empty.
- router_rdy=0; push addrs 1,2,3,4:
  - Queue is full; ni_read_addr=1 held.
  - Raise router_rdy: addrs 1,2,3,4 issue on 4 consecutive cycles, then empty.
- Full queue, with a push of addr 9 and a pop in the same cycle: addr 1 issues, count stays 4, and addr 9 issues last.
- Fifth push while full with no pop: dropped. The assertion build reports an error; only 4 requests issue.
